mem_access_unit: RTL and testbench

- Parametrised load/store unit for the MEM stage of the pipelined MIPS core.
- Generalises the combinational load-extension logic:
  - configurable data width (32/64);
  - store byte-enable generation and lane replication;
  - a valid/ready request handshake to a multi-cycle data memory with timeout;
  - a registered, size-extended load result;
  - optional address-alignment exceptions.
- Sits between the EX/MEM pipeline register and the data memory. `busy` drives the pipeline stall logic.

---
 rtl/mem_access_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage: byte-enable/lane replication on stores, size-extended
// registered loads, valid/ready request handshake and a memory-ack timeout.
// Optional misalignment exceptions are enabled with `define MEM_ACCESS_ALIGN_EXC_EN.
module mem_access_unit #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [AW-1:0]     req_addr,
    input  logic [DW-1:0]     req_wdata,
    output logic              resp_valid,
    output logic [DW-1:0]     resp_rdata,
    output logic              resp_bus_err,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW/8-1:0]   mem_be,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_ack,
    input  logic [DW-1:0]     mem_rdata,
    output logic [1:0]        dbg_state
);

    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    // Handshake: a request is accepted on any rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE and the response is a single-cycle resp_valid pulse.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              we_q, we_d;
    logic [1:0]        sz_q, sz_d;
    logic              sign_q, sign_d;
    logic [LB-1:0]     off_q, off_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [NB-1:0]     mem_be_q, mem_be_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              adel_q, adel_d;
    logic              ades_q, ades_d;

    // Request decode: sz is log2 of the access size in bytes.
    logic [1:0]        req_sz;
    logic              req_sgn;
    logic [LB:0]       req_nb;
    logic [LB-1:0]     req_mask;
    logic [LB-1:0]     req_lane;
    logic [NB-1:0]     req_be;
    logic [DW-1:0]     req_wrep;
    logic              exc_go;

    always_comb begin
        req_sz  = 2'(LB);
        req_sgn = 1'b0;
        case (req_op)
            3'd1: req_sz = 2'd0;
            3'd2: begin req_sz = 2'd0; req_sgn = 1'b1; end
            3'd3: req_sz = 2'd1;
            3'd4: begin req_sz = 2'd1; req_sgn = 1'b1; end
            3'd5: if (DW == 64) req_sz = 2'd2;
            3'd6: if (DW == 64) begin req_sz = 2'd2; req_sgn = 1'b1; end
            default: ;
        endcase
    end

    assign req_nb   = (LB+1)'(1) << req_sz;
    assign req_mask = LB'(req_nb - 1'b1);
    assign req_lane = req_addr[LB-1:0] & ~req_mask;

`ifdef MEM_ACCESS_ALIGN_EXC_EN
    assign exc_go = |(req_addr[LB-1:0] & req_mask);
`else
    assign exc_go = 1'b0;
`endif

    // Store lanes: enables cover the access bytes; data repeats the low bytes in every lane.
    always_comb begin
        req_be   = '0;
        req_wrep = '0;
        for (int b = 0; b < NB; b++) begin
            req_be[b] = ((LB+1)'(b) >= {1'b0, req_lane}) &&
                        ((LB+1)'(b) < ({1'b0, req_lane} + req_nb));
            req_wrep[b*8 +: 8] = req_wdata[{LB'(b) & req_mask, 3'b000} +: 8];
        end
    end

    logic [LB:0]   ld_nb;
    logic          ld_fill;
    logic [DW-1:0] ld_ext;

    assign ld_nb   = (LB+1)'(1) << sz_q;
    assign ld_fill = sign_q & mem_rdata[{off_q + LB'(ld_nb - 1'b1), 3'b111}];

    always_comb begin
        ld_ext = '0;
        for (int i = 0; i < NB; i++) begin
            if ((LB+1)'(i) < ld_nb) begin
                ld_ext[i*8 +: 8] = mem_rdata[{off_q + LB'(i), 3'b000} +: 8];
            end else begin
                ld_ext[i*8 +: 8] = {8{ld_fill}};
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        sz_d        = sz_q;
        sign_d      = sign_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        bus_err_d   = bus_err_q;
        adel_d      = adel_q;
        ades_d      = ades_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    sz_d        = req_sz;
                    sign_d      = req_sgn;
                    off_d       = req_lane;
                    cnt_d       = '0;
                    mem_addr_d  = {req_addr[AW-1:LB], {LB{1'b0}}};
                    mem_wdata_d = req_wrep;
                    rdata_d     = '0;
                    bus_err_d   = 1'b0;
                    if (exc_go) begin
                        state_d = S_RESP;
                        adel_d  = !req_we;
                        ades_d  = req_we;
                    end else begin
                        state_d  = S_REQ;
                        mem_we_d = req_we;
                        mem_be_d = req_be;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 16'd1;
                // An ack in the final timeout cycle still completes the access normally.
                if (mem_ack) begin
                    if (!we_q) rdata_d = ld_ext;
                    state_d  = S_RESP;
                    mem_we_d = 1'b0;
                    mem_be_d = '0;
                end else if (cnt_q == TO_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_RESP;
                    mem_we_d  = 1'b0;
                    mem_be_d  = '0;
                end
            end
            S_RESP: begin
                state_d   = S_IDLE;
                rdata_d   = '0;
                bus_err_d = 1'b0;
                adel_d    = 1'b0;
                ades_d    = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            sz_q        <= '0;
            sign_q      <= 1'b0;
            off_q       <= '0;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
            adel_q      <= 1'b0;
            ades_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            sz_q        <= sz_d;
            sign_q      <= sign_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
            adel_q      <= adel_d;
            ades_q      <= ades_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign mem_req      = (state_q == S_REQ);
    assign resp_valid   = (state_q == S_RESP);
    assign resp_rdata   = rdata_q;
    assign resp_bus_err = bus_err_q;
    assign exc_adel     = adel_q;
    assign exc_ades     = ades_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit and a 64-bit instance (TIMEOUT=4) driven by directed
// vectors; responses are scored against an expected queue holding {cycle, flags, rdata}.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    logic req_valid32, req_valid64, req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, mem_rdata;
    logic mem_ack32, mem_ack64;

    logic r32_ready, r32_valid, r32_berr, r32_adel, r32_ades, r32_busy;
    logic m32_req, m32_we;
    logic [31:0] r32_rdata, m32_addr, m32_wdata;
    logic [3:0]  m32_be;
    logic [1:0]  st32;

    logic r64_ready, r64_valid, r64_berr, r64_adel, r64_ades, r64_busy;
    logic m64_req, m64_we;
    logic [63:0] r64_rdata, m64_wdata;
    logic [31:0] m64_addr;
    logic [7:0]  m64_be;
    logic [1:0]  st64;

    mem_access_unit #(.DW(32), .AW(32), .TIMEOUT(TO)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid32), .req_ready(r32_ready), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(r32_valid), .resp_rdata(r32_rdata), .resp_bus_err(r32_berr),
        .exc_adel(r32_adel), .exc_ades(r32_ades), .busy(r32_busy),
        .mem_req(m32_req), .mem_we(m32_we), .mem_addr(m32_addr), .mem_be(m32_be),
        .mem_wdata(m32_wdata), .mem_ack(mem_ack32), .mem_rdata(mem_rdata[31:0]),
        .dbg_state(st32)
    );

    mem_access_unit #(.DW(64), .AW(32), .TIMEOUT(TO)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid64), .req_ready(r64_ready), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(r64_valid), .resp_rdata(r64_rdata), .resp_bus_err(r64_berr),
        .exc_adel(r64_adel), .exc_ades(r64_ades), .busy(r64_busy),
        .mem_req(m64_req), .mem_we(m64_we), .mem_addr(m64_addr), .mem_be(m64_be),
        .mem_wdata(m64_wdata), .mem_ack(mem_ack64), .mem_rdata(mem_rdata),
        .dbg_state(st64)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;
    logic [98:0] exp32_q[$];
    logic [98:0] exp64_q[$];

    bit sel64 = 1'b0;
    logic        mux_ready, mux_busy, mux_mreq, mux_mwe;
    logic [31:0] mux_maddr;
    logic [7:0]  mux_be;
    logic [63:0] mux_wd;
    assign mux_ready = sel64 ? r64_ready : r32_ready;
    assign mux_busy  = sel64 ? r64_busy  : r32_busy;
    assign mux_mreq  = sel64 ? m64_req   : m32_req;
    assign mux_mwe   = sel64 ? m64_we    : m32_we;
    assign mux_maddr = sel64 ? m64_addr  : m32_addr;
    assign mux_be    = sel64 ? m64_be    : {4'h0, m32_be};
    assign mux_wd    = sel64 ? m64_wdata : {32'h0, m32_wdata};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic score(input string name, input logic [98:0] got, input logic [98:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got cyc %0d flags %b rdata 0x%0h, expected cyc %0d flags %b rdata 0x%0h",
                     name, got[98:67], got[66:64], got[63:0], exp[98:67], exp[66:64], exp[63:0]);
        end
    endtask

    // Scoreboard monitors: every resp_valid cycle must match the oldest expected response.
    always @(negedge clk) begin
        if (r32_valid) begin
            if (exp32_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL resp32_unexpected: cyc %0d rdata 0x%0h", cyc, r32_rdata);
            end else begin
                score("resp32", {32'(cyc), r32_berr, r32_adel, r32_ades, 32'h0, r32_rdata},
                      exp32_q.pop_front());
            end
        end
        if (r64_valid) begin
            if (exp64_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL resp64_unexpected: cyc %0d rdata 0x%0h", cyc, r64_rdata);
            end else begin
                score("resp64", {32'(cyc), r64_berr, r64_adel, r64_ades, r64_rdata},
                      exp64_q.pop_front());
            end
        end
    end

    // Driver: one access; ack_dly < 0 means the memory never acknowledges.
    task automatic access(input bit w64, input bit we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [63:0] rdata, input int ack_dly, input bit exp_mem,
                          input logic [2:0] exp_flags, input logic [63:0] exp_rdata,
                          input logic [31:0] exp_maddr, input logic [7:0] exp_be,
                          input logic [63:0] exp_wdata);
        int k;
        int rcyc;
        sel64 = w64;
        @(negedge clk);
        chk("req_ready_idle", mux_ready, 1);
        req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        if (w64) req_valid64 = 1'b1; else req_valid32 = 1'b1;
        k = cyc;
        rcyc = !exp_mem ? k + 1 : (ack_dly < 0 ? k + 1 + TO : k + 2 + ack_dly);
        if (w64) exp64_q.push_back({32'(rcyc), exp_flags, exp_rdata});
        else     exp32_q.push_back({32'(rcyc), exp_flags, exp_rdata});
        @(negedge clk);
        req_valid32 = 1'b0; req_valid64 = 1'b0;
        chk("busy_after_accept", mux_busy, 1);
        if (exp_mem) begin
            chk("mem_we", mux_mwe, we);
            chk("mem_addr", mux_maddr, exp_maddr);
            chk("mem_be", mux_be, exp_be);
            chk("mem_wdata", mux_wd, exp_wdata);
            for (int j = 0; j < TO; j++) begin
                chk("mem_req_held", mux_mreq, 1);
                if (j == ack_dly) begin
                    mem_rdata = rdata;
                    if (w64) mem_ack64 = 1'b1; else mem_ack32 = 1'b1;
                    @(negedge clk);
                    mem_ack32 = 1'b0; mem_ack64 = 1'b0; mem_rdata = '0;
                    break;
                end
                @(negedge clk);
            end
            chk("mem_req_dropped", mux_mreq, 0);
        end else begin
            chk("mem_req_none", mux_mreq, 0);
        end
        chk("busy_resp", mux_busy, 1);
        chk("ready_resp", mux_ready, 0);
        @(negedge clk);
        chk("busy_idle", mux_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid32 = 1'b0; req_valid64 = 1'b0; req_we = 1'b0; req_op = '0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ack32 = 1'b0; mem_ack64 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready32", r32_ready, 1);
        chk("rst_busy32", r32_busy, 0);
        chk("rst_mreq32", m32_req, 0);
        chk("rst_valid32", r32_valid, 0);
        chk("rst_maddr32", m32_addr, 0);
        chk("rst_ready64", r64_ready, 1);
        chk("rst_be64", m64_be, 0);
        chk("rst_rdata64", r64_rdata, 0);
        reset = 1'b0;

        // 32-bit loads/stores across sizes, lanes and ack delays
        access(0, 0, 3'd2, 32'h1003, 64'h0, 64'h80FF_1234, 0, 1, 3'b000, 64'hFFFF_FF80, 32'h1000, 8'h8, 64'h0);
        access(0, 1, 3'd3, 32'h2002, 64'hBEEF, 64'hFFFF_FFFF, 2, 1, 3'b000, 64'h0, 32'h2000, 8'hC, 64'hBEEF_BEEF);
        access(0, 0, 3'd1, 32'h1002, 64'h0, 64'h80FF_1234, 0, 1, 3'b000, 64'h0000_00FF, 32'h1000, 8'h4, 64'h0);
        access(0, 0, 3'd4, 32'h1002, 64'h0, 64'h80FF_1234, 1, 1, 3'b000, 64'hFFFF_80FF, 32'h1000, 8'hC, 64'h0);
        access(0, 0, 3'd3, 32'h1000, 64'h0, 64'h80FF_1234, 0, 1, 3'b000, 64'h0000_1234, 32'h1000, 8'h3, 64'h0);
        access(0, 1, 3'd1, 32'h2001, 64'h1234_56A5, 64'h0, 0, 1, 3'b000, 64'h0, 32'h2000, 8'h2, 64'hA5A5_A5A5);
        access(0, 0, 3'd5, 32'h1004, 64'h0, 64'h8000_0001, 0, 1, 3'b000, 64'h8000_0001, 32'h1004, 8'hF, 64'h0);
        access(0, 1, 3'd7, 32'h3000, 64'hDEAD_BEEF, 64'h0, 0, 1, 3'b000, 64'h0, 32'h3000, 8'hF, 64'hDEAD_BEEF);
        // Timeout without ack, then ack in the last allowed cycle
        access(0, 0, 3'd0, 32'h4000, 64'h0, 64'h0, -1, 1, 3'b100, 64'h0, 32'h4000, 8'hF, 64'h0);
        access(0, 0, 3'd0, 32'h4000, 64'h0, 64'h1122_3344, TO - 1, 1, 3'b000, 64'h1122_3344, 32'h4000, 8'hF, 64'h0);
        // Misaligned accesses
`ifdef MEM_ACCESS_ALIGN_EXC_EN
        access(0, 0, 3'd0, 32'h1001, 64'h0, 64'hCAFE_F00D, 0, 0, 3'b010, 64'h0, 32'h0, 8'h0, 64'h0);
        access(0, 1, 3'd3, 32'h2001, 64'hBEEF, 64'h0, 0, 0, 3'b001, 64'h0, 32'h0, 8'h0, 64'h0);
`else
        access(0, 0, 3'd0, 32'h1001, 64'h0, 64'hCAFE_F00D, 0, 1, 3'b000, 64'hCAFE_F00D, 32'h1000, 8'hF, 64'h0);
        access(0, 1, 3'd3, 32'h2001, 64'hBEEF, 64'h0, 0, 1, 3'b000, 64'h0, 32'h2000, 8'h3, 64'hBEEF_BEEF);
`endif

        // 64-bit instance
        access(1, 0, 3'd6, 32'h8004, 64'h0, 64'h8765_4321_0000_0001, 0, 1, 3'b000, 64'hFFFF_FFFF_8765_4321, 32'h8000, 8'hF0, 64'h0);
        access(1, 0, 3'd5, 32'h8004, 64'h0, 64'h8765_4321_0000_0001, 0, 1, 3'b000, 64'h0000_0000_8765_4321, 32'h8000, 8'hF0, 64'h0);
        access(1, 1, 3'd5, 32'h8004, 64'h1234_5678, 64'h0, 1, 1, 3'b000, 64'h0, 32'h8000, 8'hF0, 64'h1234_5678_1234_5678);
        access(1, 0, 3'd4, 32'h8006, 64'h0, 64'h8765_4321_0000_0001, 0, 1, 3'b000, 64'hFFFF_FFFF_FFFF_8765, 32'h8000, 8'hC0, 64'h0);
        access(1, 0, 3'd2, 32'h8007, 64'h0, 64'h8765_4321_0000_0001, 0, 1, 3'b000, 64'hFFFF_FFFF_FFFF_FF87, 32'h8000, 8'h80, 64'h0);
        access(1, 0, 3'd0, 32'h8000, 64'h0, 64'h8765_4321_0000_0001, 0, 1, 3'b000, 64'h8765_4321_0000_0001, 32'h8000, 8'hFF, 64'h0);

        // Reset in the middle of a pending request
        sel64 = 1'b0;
        @(negedge clk);
        req_we = 1'b0; req_op = 3'd0; req_addr = 32'h3000; req_valid32 = 1'b1;
        @(negedge clk);
        req_valid32 = 1'b0;
        chk("rstmid_mreq_before", m32_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_mreq", m32_req, 0);
        chk("rstmid_busy", r32_busy, 0);
        chk("rstmid_valid", r32_valid, 0);
        chk("rstmid_ready", r32_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        mem_rdata = 64'h5555_AAAA; mem_ack32 = 1'b1;
        @(negedge clk);
        mem_ack32 = 1'b0; mem_rdata = '0;
        chk("late_ack_valid", r32_valid, 0);
        @(negedge clk);
        chk("late_ack_valid2", r32_valid, 0);
        chk("late_ack_ready", r32_ready, 1);

        repeat (3) @(negedge clk);
        chk("resp32_missing", exp32_q.size(), 0);
        chk("resp64_missing", exp64_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
